// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: serial-line, tick and SIPO-strobe signals of the UART receive sequencer
`timescale 1ns/1ps
interface uart_rx_ctrl_if;
  logic rx_in;
  logic sample_tick;
  logic rx_bit;
  logic shift;
  logic rx_done;
  logic frame_err;
  logic busy;
  modport master (
    output rx_in, sample_tick,
    input  rx_bit, shift, rx_done, frame_err, busy
  );
  modport slave (
    input  rx_in, sample_tick,
    output rx_bit, shift, rx_done, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer, samples mid-bit and strobes an external SIPO
`timescale 1ns/1ps
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic          clk,
  input  logic          clear,
  uart_rx_ctrl_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic          rx_m, rx_s;
  logic          rx_bit_n, shift_n, done_n, err_n;
  logic          tick;
  assign tick = bus.sample_tick;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      bus.rx_bit    <= 1'b1;
      bus.shift     <= 1'b0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_n;
      bit_cnt       <= bit_n;
      rx_m          <= bus.rx_in;
      rx_s          <= rx_m;
      bus.rx_bit    <= rx_bit_n;
      bus.shift     <= shift_n;
      bus.rx_done   <= done_n;
      bus.frame_err <= err_n;
      bus.busy      <= state_n != IDLE;
    end
  end
  // Counters move only on sample_tick; BRK alone reacts to rx_s every clock
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    rx_bit_n = bus.rx_bit;
    shift_n  = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE:
        if (tick && !rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      START:
        if (tick) begin
          tick_n = (tick_cnt == T_MID) ? '0 : tick_cnt + 1'b1;
          if (tick_cnt == T_MID) begin
            state_n = rx_s ? IDLE : DATA;
            bit_n   = '0;
          end
        end
      DATA:
        if (tick) begin
          tick_n = (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
          if (tick_cnt == T_END) begin
            rx_bit_n = rx_s;
            shift_n  = 1'b1;
            bit_n    = bit_cnt + 1'b1;
            state_n  = (bit_cnt == B_LAST) ? STOP : DATA;
          end
        end
      STOP:
        if (tick) begin
          tick_n = (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
          if (tick_cnt == T_END) begin
            done_n  = rx_s;
            err_n   = !rx_s;
            state_n = rx_s ? IDLE : BRK;
          end
        end
      BRK:
        state_n = rx_s ? IDLE : BRK;
      default:
        state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a behavioural SIPO built from the shift strobes
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b0;
  uart_rx_ctrl_if u_if();
  uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .clear(clear),
    .bus(u_if.slave)
  );
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  int n_shift = 0;
  int n_done = 0;
  int n_err = 0;
  logic [7:0] sipo = '0;
  logic [7:0] blog = '0;
  logic both = 1'b0;
  always @(posedge clk) begin
    if (u_if.shift) begin
      n_shift <= n_shift + 1;
      sipo <= {u_if.rx_bit, sipo[7:1]};
      blog <= {blog[6:0], u_if.rx_bit};
    end
    if (u_if.rx_done) n_done <= n_done + 1;
    if (u_if.frame_err) n_err <= n_err + 1;
    if (u_if.rx_done && u_if.frame_err) both <= 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      u_if.sample_tick = 1'b1;
      @(negedge clk);
      u_if.sample_tick = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask
  task automatic send_bit(input logic b);
    u_if.rx_in = b;
    ticks(16);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask
  int s0, d0, e0;
  initial begin
    u_if.rx_in = 1'b1;
    u_if.sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_shift", u_if.shift, 0);
    chk("rst_rx_bit", u_if.rx_bit, 1);
    chk("rst_done", u_if.rx_done, 0);
    chk("rst_err", u_if.frame_err, 0);
    clear = 1'b1;
    ticks(5);
    // frame 0xA5
    send_frame(8'hA5, 1'b1);
    chk("a5_shifts", n_shift, 8);
    chk("a5_bits", blog, 8'hA5);
    chk("a5_sipo", sipo, 8'hA5);
    chk("a5_done", n_done, 1);
    chk("a5_err", n_err, 0);
    chk("a5_idle", u_if.busy, 0);
    // false start glitch
    s0 = n_shift;
    u_if.rx_in = 1'b0;
    ticks(3);
    chk("glitch_busy", u_if.busy, 1);
    ticks(1);
    u_if.rx_in = 1'b1;
    ticks(12);
    chk("glitch_idle", u_if.busy, 0);
    chk("glitch_noshift", n_shift, s0);
    // 0x3C with low stop bit, then held low
    s0 = n_shift; d0 = n_done; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h1) != 0);
    u_if.rx_in = 1'b0;
    ticks(40);
    chk("brk_shifts", n_shift, s0 + 8);
    chk("brk_sipo", sipo, 8'h3C);
    chk("brk_err", n_err, e0 + 1);
    chk("brk_nodone", n_done, d0);
    chk("brk_busy", u_if.busy, 1);
    u_if.rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_exit", u_if.busy, 0);
    ticks(20);
    chk("brk_noframe", n_shift, s0 + 8);
    // back-to-back 0x00, 0xFF
    s0 = n_shift; d0 = n_done;
    send_frame(8'h00, 1'b1);
    chk("b2b_sipo0", sipo, 8'h00);
    send_frame(8'hFF, 1'b1);
    chk("b2b_sipo1", sipo, 8'hFF);
    chk("b2b_done", n_done, d0 + 2);
    chk("b2b_shifts", n_shift, s0 + 16);
    // reset after third shift of 0x81
    s0 = n_shift; d0 = n_done; e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("mid_shifts", n_shift, s0 + 3);
    chk("mid_rx_bit", u_if.rx_bit, 0);
    clear = 1'b0;
    #1;
    chk("clr_busy", u_if.busy, 0);
    chk("clr_rx_bit", u_if.rx_bit, 1);
    chk("clr_shift", u_if.shift, 0);
    @(negedge clk);
    clear = 1'b1;
    u_if.rx_in = 1'b1;
    ticks(10);
    chk("clr_nodone", n_done, d0);
    chk("clr_noerr", n_err, e0);
    send_frame(8'h81, 1'b1);
    chk("resend_sipo", sipo, 8'h81);
    chk("resend_done", n_done, d0 + 1);
    // tick pause mid-DATA
    s0 = n_shift; d0 = n_done;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h1) != 0);
    repeat (100) @(negedge clk);
    chk("pause_shifts", n_shift, s0 + 4);
    chk("pause_busy", u_if.busy, 1);
    for (int i = 4; i < 8; i++) send_bit(((8'h5A >> i) & 8'h1) != 0);
    send_bit(1'b1);
    chk("pause_sipo", sipo, 8'h5A);
    chk("pause_total", n_shift, s0 + 8);
    chk("pause_done", n_done, d0 + 1);
    chk("never_both", both, 0);
    chk("err_total", n_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
